// File: rtl/cordic_axil_regbank_pkg.sv
// Shared constants, types and the register-map word decoder for the CORDIC AXI4-Lite register bank.
package cordic_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CH_STRIDE = 8;

  localparam logic [2:0] OFF_XIN  = 3'd0;
  localparam logic [2:0] OFF_YIN  = 3'd1;
  localparam logic [2:0] OFF_ZIN  = 3'd2;
  localparam logic [2:0] OFF_XRES = 3'd3;
  localparam logic [2:0] OFF_YRES = 3'd4;
  localparam logic [2:0] OFF_ZRES = 3'd5;
  localparam logic [2:0] OFF_CTRL = 3'd6;

  typedef enum logic [2:0] {K_IN, K_RES, K_CTRL, K_STATUS, K_IRQEN, K_BAD} word_kind_e;

  typedef struct packed {
    logic [2:0] ch;
    word_kind_e kind;
    logic       err;
  } word_dec_t;

  // The global STATUS/IRQ_EN words sit directly after the last channel block.
  function automatic word_dec_t decode_word(input logic [31:0] idx, input int unsigned num_ch);
    word_dec_t d;
    d.ch   = idx[5:3];
    d.kind = K_BAD;
    if (idx < num_ch * CH_STRIDE) begin
      case (idx[2:0])
        OFF_XIN, OFF_YIN, OFF_ZIN:    d.kind = K_IN;
        OFF_XRES, OFF_YRES, OFF_ZRES: d.kind = K_RES;
        OFF_CTRL:                     d.kind = K_CTRL;
        default:                      d.kind = K_BAD;
      endcase
    end else if (idx == num_ch * CH_STRIDE) begin
      d.kind = K_STATUS;
    end else if (idx == num_ch * CH_STRIDE + 1) begin
      d.kind = K_IRQEN;
    end
    d.err = (d.kind == K_BAD);
    return d;
  endfunction

endpackage

// File: rtl/cordic_axil_regbank_hold_slot.sv
// One-entry valid/ready holding register; ready is registered and equals "slot empty".
module axil_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_full,
  input  logic             pop
);

  logic             full_q, full_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A fill can only happen while empty, so it never collides with a pop.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) full_d = 1'b0;
    if (in_valid && rdy_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    rdy_d = !full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
    end
  end

  assign in_ready = rdy_q;
  assign out_data = data_q;
  assign out_full = full_q;

endmodule

// File: rtl/cordic_axil_regbank.sv
// AXI4-Lite register bank for NUM_CH CORDIC channels: operand/result/control words per channel,
// a sticky W1C done STATUS word, an IRQ enable word and a registered level interrupt.
module cordic_axil_regbank
  import cordic_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_W-1:0]        s_axi_wdata,
  input  logic [DATA_W/8-1:0]      s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_W-1:0]        s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_CH*DATA_W-1:0] ch_x_in,
  output logic [NUM_CH*DATA_W-1:0] ch_y_in,
  output logic [NUM_CH*DATA_W-1:0] ch_z_in,
  output logic [NUM_CH*DATA_W-1:0] ch_ctrl,
  input  logic [NUM_CH-1:0]        ch_ctrl_we,
  input  logic [NUM_CH*DATA_W-1:0] ch_ctrl_wdata,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH*DATA_W-1:0] ch_x_res,
  input  logic [NUM_CH*DATA_W-1:0] ch_y_res,
  input  logic [NUM_CH*DATA_W-1:0] ch_z_res,
  output logic                     irq
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam logic [STRB_W-1:0] CTRL_LANES = {1'b0, {(STRB_W-1){1'b1}}};

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    return r;
  endfunction

  logic [IDX_W-1:0]         aw_idx;
  logic                     aw_full;
  logic [STRB_W+DATA_W-1:0] w_bus;
  logic [DATA_W-1:0]        w_data;
  logic [STRB_W-1:0]        w_strb;
  logic                     w_full;
  logic                     commit;

  logic [DATA_W-1:0] in_q  [NUM_CH][3];
  logic [DATA_W-1:0] in_d  [NUM_CH][3];
  logic [DATA_W-1:0] res_q [NUM_CH][3];
  logic [DATA_W-1:0] res_d [NUM_CH][3];
  logic [DATA_W-1:0] ctrl_q [NUM_CH];
  logic [DATA_W-1:0] ctrl_d [NUM_CH];
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] irqen_q, irqen_d;
  logic              irq_q, irq_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [31:0]       widx, ridx;
  word_dec_t         wdec, rdec;
  logic              werr;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

  axil_hold_slot #(.WIDTH(IDX_W)) u_aw_slot (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_axi_awaddr[ADDR_W-1:ADDR_LSB]),
    .in_valid (s_axi_awvalid),
    .in_ready (s_axi_awready),
    .out_data (aw_idx),
    .out_full (aw_full),
    .pop      (commit)
  );

  axil_hold_slot #(.WIDTH(STRB_W + DATA_W)) u_w_slot (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({s_axi_wstrb, s_axi_wdata}),
    .in_valid (s_axi_wvalid),
    .in_ready (s_axi_wready),
    .out_data (w_bus),
    .out_full (w_full),
    .pop      (commit)
  );

  assign w_strb = w_bus[STRB_W+DATA_W-1:DATA_W];
  assign w_data = w_bus[DATA_W-1:0];
  assign commit = aw_full && w_full && (!bvalid_q || s_axi_bready);

  always_comb begin
    widx     = 32'(aw_idx);
    wdec     = decode_word(widx, NUM_CH);
    werr     = wdec.err || (wdec.kind == K_RES);
    in_d     = in_q;
    res_d    = res_q;
    ctrl_d   = ctrl_q;
    status_d = status_q;
    irqen_d  = irqen_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_done[i]) begin
        res_d[i][0] = ch_x_res[i*DATA_W +: DATA_W];
        res_d[i][1] = ch_y_res[i*DATA_W +: DATA_W];
        res_d[i][2] = ch_z_res[i*DATA_W +: DATA_W];
      end
    end
    if (commit && !werr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wdec.ch == 3'(i)) begin
          for (int j = 0; j < 3; j++)
            if (wdec.kind == K_IN && widx[2:0] == 3'(j))
              in_d[i][j] = apply_strb(in_q[i][j], w_data, w_strb);
          if (wdec.kind == K_CTRL)
            ctrl_d[i] = apply_strb(ctrl_q[i], w_data, w_strb & CTRL_LANES);
        end
      end
      if (wdec.kind == K_STATUS) status_d = status_q & ~w_data[NUM_CH-1:0];
      if (wdec.kind == K_IRQEN)  irqen_d  = w_data[NUM_CH-1:0];
    end
    // Core-side updates are applied last so they win over a same-cycle bus write.
    for (int i = 0; i < NUM_CH; i++)
      if (ch_ctrl_we[i]) ctrl_d[i] = ch_ctrl_wdata[i*DATA_W +: DATA_W];
    status_d = status_d | ch_done;
    irq_d    = |(status_q & irqen_q);
    bvalid_d = bvalid_q && !s_axi_bready;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = werr ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axi_arready = !rvalid_q || s_axi_rready;

  always_comb begin
    ridx    = 32'(s_axi_araddr[ADDR_W-1:ADDR_LSB]);
    rdec    = decode_word(ridx, NUM_CH);
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rdec.ch == 3'(i)) begin
        for (int j = 0; j < 3; j++) begin
          if (rdec.kind == K_IN  && ridx[2:0] == 3'(j))     rd_word = in_q[i][j];
          if (rdec.kind == K_RES && ridx[2:0] == 3'(j + 3)) rd_word = res_q[i][j];
        end
        if (rdec.kind == K_CTRL) rd_word = ctrl_q[i];
      end
    end
    if (rdec.kind == K_STATUS) rd_word = DATA_W'(status_q);
    if (rdec.kind == K_IRQEN)  rd_word = DATA_W'(irqen_q);
    rvalid_d = rvalid_q && !s_axi_rready;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axi_arvalid && s_axi_arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rdec.err ? '0 : rd_word;
      rresp_d  = rdec.err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i] <= '0;
        for (int j = 0; j < 3; j++) begin
          in_q[i][j]  <= '0;
          res_q[i][j] <= '0;
        end
      end
      status_q <= '0;
      irqen_q  <= '0;
      irq_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      in_q     <= in_d;
      res_q    <= res_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      irqen_q  <= irqen_d;
      irq_q    <= irq_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
    assign ch_x_in[g*DATA_W +: DATA_W] = in_q[g][0];
    assign ch_y_in[g*DATA_W +: DATA_W] = in_q[g][1];
    assign ch_z_in[g*DATA_W +: DATA_W] = in_q[g][2];
    assign ch_ctrl[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_cordic_axil_regbank.sv
// Scoreboard bench for cordic_axil_regbank: expected B/R responses are queued at issue and popped on output.
module tb_cordic_axil_regbank;
  import cordic_axil_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NUM_CH = 2;
  localparam int STRB_W = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [ADDR_W-1:0]        s_axi_awaddr;
  logic                     s_axi_awvalid;
  logic                     s_axi_awready;
  logic [DATA_W-1:0]        s_axi_wdata;
  logic [STRB_W-1:0]        s_axi_wstrb;
  logic                     s_axi_wvalid;
  logic                     s_axi_wready;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;
  logic [ADDR_W-1:0]        s_axi_araddr;
  logic                     s_axi_arvalid;
  logic                     s_axi_arready;
  logic [DATA_W-1:0]        s_axi_rdata;
  logic [1:0]               s_axi_rresp;
  logic                     s_axi_rvalid;
  logic                     s_axi_rready;
  logic [NUM_CH*DATA_W-1:0] ch_x_in, ch_y_in, ch_z_in, ch_ctrl;
  logic [NUM_CH-1:0]        ch_ctrl_we;
  logic [NUM_CH*DATA_W-1:0] ch_ctrl_wdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH*DATA_W-1:0] ch_x_res, ch_y_res, ch_z_res;
  logic                     irq;

  cordic_axil_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ch_x_in(ch_x_in), .ch_y_in(ch_y_in), .ch_z_in(ch_z_in), .ch_ctrl(ch_ctrl),
    .ch_ctrl_we(ch_ctrl_we), .ch_ctrl_wdata(ch_ctrl_wdata), .ch_done(ch_done),
    .ch_x_res(ch_x_res), .ch_y_res(ch_y_res), .ch_z_res(ch_z_res), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_write(input string tag, input logic [5:0] idx, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int lead);
    logic a, w;
    logic aw_done = 1'b0, w_done = 1'b0;
    int c = 0;
    s_axi_awaddr = {idx, 2'b00};
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && c < 60) begin
      if (!aw_done && c >= lead) s_axi_awvalid = 1'b1;
      a = s_axi_awvalid && s_axi_awready;
      w = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      c++;
      if (a) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_eq({tag, "_hs"}, 64'({aw_done, w_done}), 64'd3);
    bq.push_back(resp);
  endtask

  task automatic collect_b(input string tag, output int lat);
    logic [1:0] e;
    lat = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    if (s_axi_bvalid) check_eq({tag, "_bresp"}, 64'(s_axi_bresp), 64'(e));
    else              check_eq({tag, "_bvalid_timeout"}, 64'(s_axi_bvalid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input string tag, input logic [5:0] idx, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    int lat;
    send_write(tag, idx, data, strb, resp, 0);
    collect_b(tag, lat);
  endtask

  task automatic do_read(input string tag, input logic [5:0] idx, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    logic hs;
    logic [33:0] e;
    int c = 0;
    rq.push_back({exp_data, exp_resp});
    s_axi_araddr  = {idx, 2'b00};
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    do begin
      hs = s_axi_arready;
      @(posedge clk); #1;
      c++;
    end while (!hs && c < 20);
    s_axi_arvalid = 1'b0;
    e = rq.pop_front();
    if (s_axi_rvalid) begin
      check_eq({tag, "_rdata"}, 64'(s_axi_rdata), 64'(e[33:2]));
      check_eq({tag, "_rresp"}, 64'(s_axi_rresp), 64'(e[1:0]));
    end else begin
      check_eq({tag, "_rvalid_timeout"}, 64'(s_axi_rvalid), 64'd1);
    end
    @(posedge clk); #1;
  endtask

  // Drives one AW+W pair so that the commit edge coincides with a core-side event.
  task automatic write_with_side(input string tag, input logic [5:0] idx, input logic [31:0] data,
                                 input int side);
    logic hs;
    int lat;
    s_axi_awaddr  = {idx, 2'b00};
    s_axi_wdata   = data;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    hs = s_axi_awready && s_axi_wready;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_eq({tag, "_hs"}, 64'(hs), 64'd1);
    bq.push_back(RESP_OKAY);
    if (side == 1) begin
      ch_done = 2'b10;
    end else begin
      ch_ctrl_we    = 2'b01;
      ch_ctrl_wdata = {32'h0, 32'h5};
    end
    @(posedge clk); #1;
    ch_done    = '0;
    ch_ctrl_we = '0;
    collect_b(tag, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; ch_ctrl_we = '0; ch_ctrl_wdata = '0; ch_done = '0;
    ch_x_res = '0; ch_y_res = '0; ch_z_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", 64'(s_axi_awready), 64'd0);
    check_eq("rst_wready",  64'(s_axi_wready),  64'd0);
    check_eq("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    check_eq("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
    check_eq("rst_irq",     64'(irq),           64'd0);
    check_eq("rst_x_in",    64'(ch_x_in),       64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_awready", 64'(s_axi_awready), 64'd1);
    check_eq("post_rst_wready",  64'(s_axi_wready),  64'd1);

    // Basic write, latency and readback
    send_write("t1_wr", 6'd0, 32'h12345678, 4'hF, RESP_OKAY, 0);
    collect_b("t1_wr", lat);
    check_eq("t1_b_latency", 64'(lat), 64'd1);
    check_eq("t1_x_in0", 64'(ch_x_in[31:0]), 64'h12345678);
    do_read("t1_rd", 6'd0, 32'h12345678, RESP_OKAY);
    do_write("t1_z_full", 6'd2, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
    do_write("t1_z_part", 6'd2, 32'h11223344, 4'b0011, RESP_OKAY);
    check_eq("t1_z_in0_strb", 64'(ch_z_in[31:0]), 64'hFFFF3344);

    // W leads AW; ctrl top lane is read-only from the bus
    send_write("t2_wr", 6'd14, 32'hAABBCCDD, 4'hF, RESP_OKAY, 3);
    collect_b("t2_wr", lat);
    check_eq("t2_ctrl1", 64'(ch_ctrl[63:32]), 64'h00BBCCDD);
    do_read("t2_rd", 6'd14, 32'h00BBCCDD, RESP_OKAY);

    // Result capture, STATUS, IRQ
    ch_x_res = {32'h100, 32'h0};
    ch_y_res = {32'h200, 32'h0};
    ch_done  = 2'b10;
    @(posedge clk); #1;
    ch_done  = '0;
    ch_x_res = {32'hDEAD, 32'hBEEF};
    do_read("t3_xres1", 6'd11, 32'h100, RESP_OKAY);
    do_read("t3_yres1", 6'd12, 32'h200, RESP_OKAY);
    do_read("t3_xres0", 6'd3, 32'h0, RESP_OKAY);
    do_read("t3_status", 6'd16, 32'h2, RESP_OKAY);
    check_eq("t3_irq_disabled", 64'(irq), 64'd0);
    do_write("t3_irqen", 6'd17, 32'h2, 4'hF, RESP_OKAY);
    check_eq("t3_irq_on", 64'(irq), 64'd1);
    do_write("t3_w1c", 6'd16, 32'h2, 4'hF, RESP_OKAY);
    check_eq("t3_irq_off", 64'(irq), 64'd0);
    do_read("t3_status_clr", 6'd16, 32'h0, RESP_OKAY);
    ch_done = 2'b10;
    @(posedge clk); #1;
    ch_done = '0;
    check_eq("t3_irq_delay", 64'(irq), 64'd0);
    @(posedge clk); #1;
    check_eq("t3_irq_rise", 64'(irq), 64'd1);
    do_write("t3_w1c2", 6'd16, 32'h2, 4'hF, RESP_OKAY);
    write_with_side("t3_w1c_vs_done", 6'd16, 32'h2, 1);
    do_read("t3_status_setwins", 6'd16, 32'h2, RESP_OKAY);

    // Error decoding
    do_write("t4_wr_ro", 6'd3, 32'h0000FFFF, 4'hF, RESP_SLVERR);
    do_write("t4_wr_rsvd", 6'd7, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    do_write("t4_wr_oob", 6'd18, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
    do_read("t4_rd_ro", 6'd3, 32'h0, RESP_OKAY);
    do_read("t4_rd_rsvd", 6'd7, 32'h0, RESP_SLVERR);
    do_read("t4_rd_oob", 6'd18, 32'h0, RESP_SLVERR);
    do_read("t4_irqen_kept", 6'd17, 32'h2, RESP_OKAY);
    check_eq("t4_ctrl0_kept", 64'(ch_ctrl[31:0]), 64'h0);
    check_eq("t4_x_in0_kept", 64'(ch_x_in[31:0]), 64'h12345678);

    // B back-pressure fills both slots
    s_axi_bready = 1'b0;
    send_write("t5_first", 6'd1, 32'hA1, 4'hF, RESP_OKAY, 0);
    send_write("t5_second", 6'd1, 32'hB2, 4'hF, RESP_OKAY, 0);
    check_eq("t5_awready_full", 64'(s_axi_awready), 64'd0);
    check_eq("t5_wready_full",  64'(s_axi_wready),  64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_bvalid_held", 64'(s_axi_bvalid), 64'd1);
    check_eq("t5_no_commit", 64'(ch_y_in[31:0]), 64'hA1);
    collect_b("t5_first", lat);
    collect_b("t5_second", lat);
    check_eq("t5_second_commit", 64'(ch_y_in[31:0]), 64'hB2);

    // Core ctrl write beats bus write
    do_write("t6_bus_ctrl", 6'd6, 32'h9, 4'hF, RESP_OKAY);
    check_eq("t6_ctrl0_bus", 64'(ch_ctrl[31:0]), 64'h9);
    write_with_side("t6_collide", 6'd6, 32'h9, 2);
    check_eq("t6_ctrl0_core", 64'(ch_ctrl[31:0]), 64'h5);

    // Held read data, then reset discards it
    s_axi_rready  = 1'b0;
    s_axi_araddr  = 8'h00;
    s_axi_arvalid = 1'b1;
    rq.push_back({32'h12345678, RESP_OKAY});
    lat = 0;
    while (!s_axi_arready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check_eq("t6_rvalid", 64'(s_axi_rvalid), 64'd1);
    check_eq("t6_rdata", 64'(s_axi_rdata), 64'(rq[0][33:2]));
    @(posedge clk); #1;
    check_eq("t6_rdata_stable", 64'(s_axi_rdata), 64'(rq[0][33:2]));
    check_eq("t6_rvalid_stable", 64'(s_axi_rvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rq.delete();
    check_eq("t6_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check_eq("t6_rst_x_in", 64'(ch_x_in), 64'd0);
    check_eq("t6_rst_awready", 64'(s_axi_awready), 64'd0);
    rst = 1'b0;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_post_rst_awready", 64'(s_axi_awready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_axil_regbank.md
Name: cordic_axil_regbank

Overview:
Parametrised AXI4-Lite register bank that fronts NUM_CH independent CORDIC channels. Each channel gets its own x/y/z input, result and control registers. A global W1C done-status register and an interrupt enable register drive a level interrupt. Compared with the single-channel manager it adds:
- independent AW/W acceptance;
- SLVERR decoding;
- result capture on a done strobe instead of every cycle;
- interrupt support.

Parameters:
DATA_W, 32, AXI data and register width (multiple of 8, 32 or 64).
ADDR_W, 8, AXI byte-address width; must cover (NUM_CH*8+2) words.
NUM_CH, 2, number of CORDIC channels (1..8).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
ch_x_in, ch_y_in, ch_z_in  out  NUM_CH*DATA_W  per-channel operands; channel i is bits [i*DATA_W +: DATA_W]
ch_ctrl  out  NUM_CH*DATA_W  per-channel control register
ch_ctrl_we  in  NUM_CH  core writes control register
ch_ctrl_wdata  in  NUM_CH*DATA_W  core control write data
ch_done  in  NUM_CH  one-cycle result-valid strobe
ch_x_res, ch_y_res, ch_z_res  in  NUM_CH*DATA_W  core results
irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - All registers, outputs and ready/valid signals are 0.
  - Holding slots are empty.
  - awready and wready go to 1 on the first cycle after rst deasserts.
- Reset mid-transaction: in-flight AW, W, B, AR and R state is discarded with no response.
- Word index = addr[ADDR_W-1:ADDR_LSB], where ADDR_LSB = log2(DATA_W/8).
- Channel map, for index ch*8+k:
  - k=0,1,2: x_in, y_in, z_in; RW, byte-strobed.
  - k=3,4,5: x_res, y_res, z_res; RO.
  - k=6: ctrl; RW, top byte lane RO from the bus.
  - k=7: reserved.
- Global map:
  - Index NUM_CH*8: STATUS, bit i = channel i done sticky; W1C.
  - Index NUM_CH*8+1: IRQ_EN, bits [NUM_CH-1:0] RW.
- Error responses, SLVERR (2'b10):
  - Any access to k=7 or to an index ≥ NUM_CH*8+2.
  - Any write to a RO result register.
  - Erroring writes have no effect; erroring reads return rdata 0.
  - Everything else returns OKAY (2'b00).
- Write path:
  - AW and W each have a one-entry holding slot.
  - awready = !aw_full and wready = !w_full, both registered.
  - A handshake fills the slot.
  - Commit occurs when aw_full && w_full && (!bvalid || bready).
  - On commit: the register write happens, both slots empty, and bvalid/bresp load on the same edge.
  - Latency: AW and W presented together at edge 0 → commit at edge 1 → bvalid visible after edge 1. AW and W may arrive in any order, or cycles apart.
  - With bready held at 1: one write per 2 cycles.
- Read path:
  - arready = !rvalid || rready, i.e. rvalid is allowed to clear this cycle.
  - On an AR handshake, rdata/rresp/rvalid load on the same edge, so latency is 1 cycle.
  - rdata and rresp are held stable while rvalid && !rready.
- Simultaneous read and write: reads and writes are independent. A read in the same cycle as a commit to the same register returns the old value.
- Result capture: on ch_done[i], the three result registers of channel i load and STATUS[i] sets. Without a strobe, the result registers hold their value.
- ch_ctrl write priority: ch_ctrl_we[i] overrides a same-cycle bus write to ctrl[i]. The bus still receives OKAY.
- STATUS: if a set (ch_done) and a W1C clear happen in the same cycle, the set wins.
- irq = |(STATUS & IRQ_EN), registered, so irq rises 1 cycle after STATUS[i] with IRQ_EN[i] set.

Decomposition:
- Package cordic_axil_pkg holds:
  - RESP_OKAY/RESP_SLVERR;
  - per-channel offsets OFF_XIN..OFF_CTRL, CH_STRIDE=8;
  - function decode_word(index) returning a typedef'd struct {ch, kind, err}, with kind as an enum {K_IN, K_RES, K_CTRL, K_STATUS, K_IRQEN, K_BAD}.
- Sub-module axil_hold_slot (parametrised WIDTH): one-entry valid/ready holding register, instantiated for AW and for W.

Test Plan:
1. After reset, write 0x12345678 to index 0 (ch0 x_in) with AW and W together, strb 4'hF → bvalid after 2 edges, bresp 0, ch_x_in[31:0]=0x12345678; read back gives the same value with rresp 0.
2. Present W three cycles before AW; write 0xAABBCCDD to ch1 ctrl (index 14) with strb 4'hF → ctrl = 0x00BBCCDD. Top lane is RO.
3. Pulse ch_done[1] with x_res=0x100 → read index 11 gives 0x100 and STATUS=0x2. With IRQ_EN=0x2, irq=1 one cycle later. W1C 0x2 → irq=0. A W1C in the same cycle as ch_done → STATUS stays 0x2.
4. Write index 3 (RO), then index 7, then index NUM_CH*8+2 → each gives bresp 2'b10 and no register changes; reading index 7 returns rdata 0 with rresp 2'b10.
5. Hold bready=0 after one write and issue a second AW/W → both slots fill, awready=wready=0, no commit until bready=1; then bvalid is re-asserted for the second write.
6. Same-cycle ch_ctrl_we[0] with data 0x5 and bus write of 0x9 to ch0 ctrl → ctrl = 0x5 and bresp OKAY. Assert rst mid-read → rvalid=0 the next cycle.
